// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - read-side FIFO drain into a backpressure-safe valid/ready stream
module fifo_rd_drain #(
    parameter int Data_Width = 8,
    parameter int BUF_DEPTH  = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rstn,
    input  logic                  go,
    input  logic                  flush,
    input  logic                  empty,
    input  logic [Data_Width-1:0] data_out,
    output logic                  rd_en,
    output logic                  m_valid,
    output logic [Data_Width-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_W-1:0]      xfer_cnt
);
    localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam int SW = OW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BUF_DEPTH - 1);
    localparam logic [SW-1:0] DEPTH_S  = SW'(BUF_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN} state_t;

    state_t                state;
    logic [Data_Width-1:0] mem [BUF_DEPTH];
    logic [IW-1:0]         head;
    logic [IW-1:0]         tail;
    logic [OW-1:0]         occ;
    logic                  inflight;
    logic                  push;
    logic                  pop;
    logic [SW-1:0]         credit_used;

    // Credits count both buffered words and the read still in flight, so a
    // capture always finds a free slot even when downstream stalls.
    always_comb begin
        credit_used = {1'b0, occ} + {{OW{1'b0}}, inflight};
        rd_en       = (state == ST_ACTIVE) && !empty && !flush && (credit_used < DEPTH_S);
        m_valid     = (occ != '0);
        m_data      = m_valid ? mem[head] : '0;
        push        = inflight && !flush;
        pop         = m_valid && m_ready;
    end

    // Control FSM; busy is registered alongside the state so it is glitch-free.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state <= ST_ACTIVE;
                        busy  <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (!go) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (go) begin
                        state <= ST_ACTIVE;
                    end else if ((occ == '0) && !inflight) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Skid buffer bookkeeping; indices wrap explicitly so any depth works.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (flush) begin
                head <= '0;
                tail <= '0;
                occ  <= '0;
            end else begin
                if (push) tail <= (tail == LAST_IDX) ? '0 : tail + 1'b1;
                if (pop)  head <= (head == LAST_IDX) ? '0 : head + 1'b1;
                case ({push, pop})
                    2'b10:   occ <= occ + 1'b1;
                    2'b01:   occ <= occ - 1'b1;
                    default: occ <= occ;
                endcase
            end
        end
    end

    // Buffer storage needs no reset; m_data is masked while the buffer is empty.
    always_ff @(posedge rd_clk) begin
        if (push) mem[tail] <= data_out;
    end

    // Delivered-word counter; a pop during flush still counts, and it wraps freely.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            xfer_cnt <= '0;
        end else if (pop) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

endmodule
